// File: rtl/cmd_pkg.sv
// Command-path types shared by the frame parser, dispatcher and response FIFO.
package cmd_pkg;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_packet_t;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_DATA,
        ST_CSUM
    } parser_state_t;

    function automatic logic is_valid_op(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/cmd_frame_parser.sv
// Turns the UART RX byte stream (SOF, opcode, addr, data, csum) into cmd_fifo writes,
// discarding and counting malformed, timed-out, aborted or overflowing frames.
module cmd_frame_parser
    import cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        rx_frame_err,
    input  logic        cmd_full,
    output cmd_packet_t cmd_wr_data,
    output logic        cmd_wr_en,
    output logic        err_pulse,
    output logic [7:0]  err_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    parser_state_t state_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    csum_q;
    cmd_packet_t   pkt_q;
    cmd_packet_t   wr_data_q;
    logic          wr_en_q;
    logic          err_pulse_q;
    logic [7:0]    err_count_q;

    logic in_frame_d;
    logic byte_d;
    logic abort_d;
    logic tmo_hit_d;
    logic bad_op_d;
    logic csum_ok_d;
    logic bad_csum_d;
    logic err_d;
    logic wr_d;

    // A frame error in the same cycle as a byte wins: the byte is dropped.
    assign in_frame_d = (state_q != ST_IDLE);
    assign byte_d     = rx_valid && !rx_frame_err;
    assign abort_d    = in_frame_d && rx_frame_err;
    assign tmo_hit_d  = in_frame_d && !rx_valid && (tmo_q == TMO_LIMIT);
    assign bad_op_d   = byte_d && (state_q == ST_OPCODE) && !is_valid_op(rx_byte);
    assign csum_ok_d  = (rx_byte == csum_q);
    assign bad_csum_d = byte_d && (state_q == ST_CSUM) && (!csum_ok_d || cmd_full);
    assign err_d      = abort_d || tmo_hit_d || bad_op_d || bad_csum_d;
    assign wr_d       = byte_d && (state_q == ST_CSUM) && csum_ok_d && !cmd_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            csum_q      <= '0;
            pkt_q       <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            wr_en_q     <= wr_d;
            err_pulse_q <= err_d;
            if (err_d && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
            if (wr_d) begin
                wr_data_q.opcode <= pkt_q.opcode;
                wr_data_q.addr   <= pkt_q.addr;
                wr_data_q.data   <= (pkt_q.opcode == OP_READ) ? 8'h00 : pkt_q.data;
            end

            if (state_q == ST_IDLE) begin
                csum_q <= '0;
            end

            if (err_d) begin
                state_q <= ST_IDLE;
                tmo_q   <= '0;
            end else begin
                if (byte_d) begin
                    tmo_q <= '0;
                end else if (in_frame_d) begin
                    tmo_q <= tmo_q + 1'b1;
                end

                if (byte_d) begin
                    unique case (state_q)
                        ST_IDLE: begin
                            if (rx_byte == SOF_BYTE) begin
                                state_q <= ST_OPCODE;
                            end
                        end
                        ST_OPCODE: begin
                            pkt_q.opcode <= rx_byte;
                            csum_q       <= csum_q ^ rx_byte;
                            state_q      <= ST_ADDR;
                        end
                        ST_ADDR: begin
                            pkt_q.addr <= rx_byte;
                            csum_q     <= csum_q ^ rx_byte;
                            state_q    <= ST_DATA;
                        end
                        ST_DATA: begin
                            pkt_q.data <= rx_byte;
                            csum_q     <= csum_q ^ rx_byte;
                            state_q    <= ST_CSUM;
                        end
                        ST_CSUM: begin
                            state_q <= ST_IDLE;
                        end
                        default: begin
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign cmd_wr_data = wr_data_q;
    assign cmd_wr_en   = wr_en_q;
    assign err_pulse   = err_pulse_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Self-checking bench for cmd_frame_parser: frame table plus hand-built corner sequences,
// with expected writes queued on stimulus and matched as cmd_wr_en appears.
module tb_cmd_frame_parser;
    import cmd_pkg::*;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_frame_err;
    logic        cmd_full;
    cmd_packet_t cmd_wr_data;
    logic        cmd_wr_en;
    logic        err_pulse;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    cmd_frame_parser #(
        .TIMEOUT_CYCLES(TMO),
        .SOF_BYTE      (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .cmd_full    (cmd_full),
        .cmd_wr_data (cmd_wr_data),
        .cmd_wr_en   (cmd_wr_en),
        .err_pulse   (err_pulse),
        .err_count   (err_count)
    );

    typedef struct {
        logic [4:0][7:0] bytes;
        logic            full;
        logic            exp_wr;
        int              exp_err;
        logic [23:0]     pkt;
    } vec_t;

    int          checks    = 0;
    int          errors    = 0;
    int          err_seen  = 0;
    int          model_cnt = 0;
    cmd_packet_t exp_q[$];
    vec_t        vecs[9];

    function automatic vec_t mk(input logic [39:0] b, input logic f, input logic w,
                                input int e, input logic [23:0] p);
        vec_t v;
        v.bytes   = b;
        v.full    = f;
        v.exp_wr  = w;
        v.exp_err = e;
        v.pkt     = p;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        cmd_packet_t p;
        @(posedge clk);
        #1;
        if (cmd_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h expected no write", cmd_wr_data);
            end else begin
                p = exp_q.pop_front();
                check("wr_data", cmd_wr_data, p);
            end
        end
        if (err_pulse) err_seen++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic expect_frame(input string tag, input int e0, input int exp_errs);
        model_cnt = (model_cnt + exp_errs > 255) ? 255 : model_cnt + exp_errs;
        check({tag, "_errs"}, err_seen - e0, exp_errs);
        check({tag, "_err_count"}, err_count, model_cnt);
        check({tag, "_pending"}, exp_q.size(), 0);
        $display("frame %s: err_pulses=%0d err_count=%0h", tag, err_seen - e0, err_count);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int e0;
        e0 = err_seen;
        for (int i = 4; i >= 0; i--) begin
            if (i == 0) begin
                cmd_full = v.full;
                if (v.exp_wr) exp_q.push_back(v.pkt);
            end
            send_byte(v.bytes[i]);
            cmd_full = 1'b0;
        end
        expect_frame(tag, e0, v.exp_err);
    endtask

    initial begin
        int e0;
        int n;

        vecs[0] = mk({8'hA5, 8'h02, 8'h10, 8'h3C, 8'h2E}, 0, 1, 0, {8'h02, 8'h10, 8'h3C});
        vecs[1] = mk({8'hA5, 8'h01, 8'h20, 8'hFF, 8'hDE}, 0, 1, 0, {8'h01, 8'h20, 8'h00});
        vecs[2] = mk({8'hA5, 8'h02, 8'h10, 8'h3C, 8'h00}, 0, 0, 1, 24'h0);
        vecs[3] = mk({8'hA5, 8'h07, 8'h10, 8'h3C, 8'h2B}, 0, 0, 1, 24'h0);
        vecs[4] = mk({8'hA5, 8'h02, 8'h55, 8'hAA, 8'hFD}, 0, 1, 0, {8'h02, 8'h55, 8'hAA});
        vecs[5] = mk({8'hA5, 8'h02, 8'h10, 8'h3C, 8'h2E}, 1, 0, 1, 24'h0);
        vecs[6] = mk({8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02}, 0, 1, 0, {8'h02, 8'hA5, 8'hA5});
        vecs[7] = mk({8'hA5, 8'h01, 8'h00, 8'h00, 8'h01}, 0, 1, 0, {8'h01, 8'h00, 8'h00});
        vecs[8] = mk({8'hA5, 8'h01, 8'h33, 8'h5A, 8'h68}, 0, 1, 0, {8'h01, 8'h33, 8'h00});

        rst          = 1'b1;
        rx_byte      = 8'h00;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        cmd_full     = 1'b0;
        repeat (3) tick();
        check("rst_wr_en", cmd_wr_en, 0);
        check("rst_wr_data", cmd_wr_data, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_count", err_count, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Noise bytes in IDLE are ignored silently.
        send_byte(8'h11);
        send_byte(8'h22);
        run_frame(vecs[0], "noise_then_frame");

        // Inter-byte timeout after SOF + opcode.
        e0 = err_seen;
        send_byte(8'hA5);
        send_byte(8'h02);
        n = 3;
        while (err_seen == e0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n < TMO || n > TMO + 2) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", n, TMO, TMO + 2);
        end
        expect_frame("timeout", e0, 1);
        run_frame(vecs[0], "after_timeout");

        // Frame error while in ADDR aborts; the tail bytes are then ignored.
        e0 = err_seen;
        send_byte(8'hA5);
        send_byte(8'h02);
        rx_frame_err = 1'b1;
        tick();
        rx_frame_err = 1'b0;
        repeat (3) tick();
        send_byte(8'h10);
        send_byte(8'h3C);
        send_byte(8'h2E);
        expect_frame("abort_addr", e0, 1);

        // Frame error in IDLE is ignored.
        e0 = err_seen;
        rx_frame_err = 1'b1;
        tick();
        rx_frame_err = 1'b0;
        repeat (3) tick();
        expect_frame("ferr_idle", e0, 0);

        // Frame error coinciding with a byte: error wins, byte dropped.
        e0 = err_seen;
        send_byte(8'hA5);
        rx_byte      = 8'h02;
        rx_valid     = 1'b1;
        rx_frame_err = 1'b1;
        tick();
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        repeat (3) tick();
        send_byte(8'h10);
        send_byte(8'h3C);
        send_byte(8'h2E);
        expect_frame("ferr_with_byte", e0, 1);

        // Reset mid-frame discards the partial frame and clears the count.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        e0  = err_seen;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        model_cnt = 0;
        send_byte(8'h3C);
        send_byte(8'h2E);
        expect_frame("rst_mid_frame", e0, 0);
        run_frame(vecs[0], "after_reset");

        // 300 bad-opcode frames saturate err_count.
        e0 = err_seen;
        for (int k = 0; k < 300; k++) begin
            send_byte(8'hA5);
            send_byte(8'h07);
        end
        expect_frame("saturate", e0, 300);
        run_frame(vecs[2], "bad_after_saturate");
        run_frame(vecs[1], "good_after_saturate");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

Assembles the serial byte stream delivered by the UART receiver into `cmd_packet_t` commands and writes them into the command FIFO that feeds `cmd_dispatcher`. It sits between the UART RX byte output and the cmd_fifo write port. It validates framing, opcode and checksum, and enforces an inter-byte timeout. Malformed frames are discarded and counted, never forwarded.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: maximum number of clk cycles allowed between consecutive bytes of one frame.
- `SOF_BYTE`, default 8'hA5: start-of-frame marker.

Ports:
- `clk`  input  1  system clock; the block has one clock.
- `rst`  input  1  reset; synchronous, active-high.
- `rx_byte`  input  8  received byte from UART RX. Valid only when `rx_valid` is high.
- `rx_valid`  input  1  one-cycle strobe: `rx_byte` holds a new byte.
- `rx_frame_err`  input  1  one-cycle strobe: UART RX detected a bad stop bit.
- `cmd_full`  input  1  cmd_fifo full.
- `cmd_wr_data`  output  `cmd_packet_t`  assembled command: opcode, addr, data.
- `cmd_wr_en`  output  1  one-cycle write strobe into cmd_fifo.
- `err_pulse`  output  1  one-cycle strobe on any discarded frame.
- `err_count`  output  8  saturating count of discarded frames.

## Operation
- Frame format is 5 bytes: SOF, opcode, addr, data, csum.
- Required checksum: csum == opcode ^ addr ^ data.
- Valid opcodes: `OP_READ` = 8'h01 and `OP_WRITE` = 8'h02. For reads, the data byte is still transmitted and included in the checksum, but `cmd_wr_data.data` is forced to 8'h00.
- FSM states: IDLE, OPCODE, ADDR, DATA, CSUM. A state advances only on a cycle where `rx_valid` is high.
  - IDLE: a byte equal to `SOF_BYTE` moves to OPCODE. Any other byte is silently ignored (no error).
  - OPCODE: an invalid opcode returns to IDLE with an error. A valid opcode is latched and the FSM moves to ADDR.
  - ADDR: latch addr, move to DATA.
  - DATA: latch data, move to CSUM.
  - CSUM: always returns to IDLE.
    - Checksum mismatch → error.
    - Checksum matches and `cmd_full` is high → error (overflow drop).
    - Otherwise → write the command.
- Timeout: a counter of width $clog2(TIMEOUT_CYCLES+1) clears on every `rx_valid` and on entry to IDLE. It counts only in non-IDLE states. When it reaches `TIMEOUT_CYCLES`: return to IDLE with an error.
- `rx_frame_err` in a non-IDLE state aborts to IDLE with an error. In IDLE it is ignored.
- If `rx_frame_err` and `rx_valid` are high in the same cycle, the frame error wins and the byte is discarded.
- A byte equal to `SOF_BYTE` in a non-IDLE state is treated as ordinary data; it does not resynchronise.
- `err_count` saturates at 8'hFF. Each error event increments it by exactly 1.
- At most one error per frame: abort, timeout, opcode, checksum and overflow are mutually exclusive because each one returns the FSM to IDLE.

## Timing
- Reset values:
  - state = IDLE
  - `cmd_wr_en` = 0
  - `cmd_wr_data` = '0
  - `err_pulse` = 0
  - `err_count` = 0
  - timeout counter = 0
- All outputs are registered.
- `cmd_wr_en` and `cmd_wr_data` are valid in the cycle after the `rx_valid` cycle of the csum byte (latency 1).
- `cmd_full` is sampled in the csum `rx_valid` cycle.
- `cmd_wr_data` holds its value until the next write.
- `err_pulse` asserts in the cycle after the error condition. `err_count` updates in that same cycle.
- The block never applies backpressure. UART RX byte spacing is at least 10 baud periods, so back-to-back `rx_valid` in consecutive cycles need not be supported. Even so, every `rx_valid` is consumed.
- Asserting `rst` mid-frame discards any partial frame. No write and no error is generated.

## Structure
- `cmd_pkg` holds:
  - `cmd_packet_t` (opcode, addr, data; 8 bits each)
  - `OP_READ` and `OP_WRITE`
  - the FSM state enum `parser_state_t`
- `cmd_pkg` is shared with `cmd_dispatcher` and `resp_fifo`.
- No sub-module: the timeout counter and checksum accumulator are inline. The checksum is a running XOR register cleared in IDLE.

## Test plan
- Valid write: A5 02 10 3C 2E → one `cmd_wr_en` with {02,10,3C}; `err_count` stays 0.
- Valid read: A5 01 20 FF DE → `cmd_wr_en` with {01,20,00}.
- Bad checksum (A5 02 10 3C 00) and bad opcode (A5 07 …) → no write; `err_pulse` twice; `err_count` = 2. A following valid frame is accepted.
- Noise then frame (11 22 A5 02 10 3C 2E) → exactly one write, no error.
- With `TIMEOUT_CYCLES` = 100: send A5 02, then idle 100 cycles → `err_pulse`, FSM returns to IDLE. A fresh frame is then accepted. Also: `rx_frame_err` during ADDR → abort with 1 error.
- `cmd_full` = 1 during the csum byte of a valid frame → no write, 1 error. Drive 300 bad frames → `err_count` saturates at FF. `rst` mid-frame → no write, no error.
